// File: rtl/wb_timer_pkg.sv
// Shared register map and control-bit layout for the Wishbone timer/PWM block.
package wb_timer_pkg;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_PSC   = 3'd1;
  localparam logic [2:0] REG_LOAD  = 3'd2;
  localparam logic [2:0] REG_COUNT = 3'd3;
  localparam logic [2:0] REG_STAT  = 3'd4;
  localparam logic [2:0] REG_DUTY  = 3'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_PWM_EN  = 3;
  localparam int CTRL_WD      = 4;

  localparam int STAT_TO = 0;

  // Expands Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescaler: counts 0..psc_i while enabled and emits a one-clock tick on the
// terminal value; held at zero while disabled or cleared.
module wb_timer_prescaler #(
  parameter int PSC_WD = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [PSC_WD-1:0] psc_i,
  output logic              tick_o
);

  logic [PSC_WD-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == psc_i);

  always_comb begin
    cnt_d = cnt_q + PSC_WD'(1);
    if (!en_i || clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_timer_pwm.sv
// Wishbone timer with prescaled down-counter, sticky timeout IRQ and optional
// PWM output (enabled by defining WB_TIMER_PWM_EN).
module wb_timer_pwm
  import wb_timer_pkg::*;
#(
  parameter int CNT_WD = 32,
  parameter int PSC_WD = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o,
  output logic        pwm_o
);

`ifdef WB_TIMER_PWM_EN
  localparam logic [CTRL_WD-1:0] CTRL_MASK = '1;
`else
  localparam logic [CTRL_WD-1:0] CTRL_MASK = ~(CTRL_WD'(1) << CTRL_PWM_EN);
`endif

  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [CTRL_WD-1:0] ctrl_q, ctrl_d, ctrl_wv;
  logic [PSC_WD-1:0]  psc_q, psc_d;
  logic [CNT_WD-1:0]  load_q, load_d, load_wv;
  logic [CNT_WD-1:0]  count_q, count_d;
  logic               to_q, to_d;
  logic               irq_q, irq_d;
  logic               pwm_q, pwm_d;
`ifdef WB_TIMER_PWM_EN
  logic [CNT_WD-1:0]  duty_q, duty_d;
`endif

  logic        req, wr, rd, tick, timeout, psc_clr;
  logic [31:0] wmask, rdata;

  assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr    = req & wb_we_i;
  assign rd    = req & ~wb_we_i;
  assign wmask = byte_mask(wb_sel_i);

  assign ctrl_wv = ((ctrl_q & ~wmask[CTRL_WD-1:0]) | (wb_dat_i[CTRL_WD-1:0] & wmask[CTRL_WD-1:0]))
                   & CTRL_MASK;
  assign load_wv = (load_q & ~wmask[CNT_WD-1:0]) | (wb_dat_i[CNT_WD-1:0] & wmask[CNT_WD-1:0]);

  // Prescaler restarts from zero whenever software turns EN on.
  assign psc_clr = wr && (wb_adr_i == REG_CTRL) && !ctrl_q[CTRL_EN] && ctrl_wv[CTRL_EN];

  wb_timer_prescaler #(.PSC_WD(PSC_WD)) u_psc (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .en_i    (ctrl_q[CTRL_EN]),
    .clear_i (psc_clr),
    .psc_i   (psc_q),
    .tick_o  (tick)
  );

  assign timeout = tick && (count_q == '0);

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      REG_CTRL:  rdata = 32'(ctrl_q);
      REG_PSC:   rdata = 32'(psc_q);
      REG_LOAD:  rdata = 32'(load_q);
      REG_COUNT: rdata = 32'(count_q);
      REG_STAT:  rdata[STAT_TO] = to_q;
`ifdef WB_TIMER_PWM_EN
      REG_DUTY:  rdata = 32'(duty_q);
`endif
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    ack_d = req;
    dat_d = rd ? rdata : dat_q;

    // A bus write to CTRL overrides the one-shot auto-clear of EN.
    ctrl_d = ctrl_q;
    if (timeout && ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr && wb_adr_i == REG_CTRL) ctrl_d = ctrl_wv;

    psc_d = psc_q;
    if (wr && wb_adr_i == REG_PSC)
      psc_d = (psc_q & ~wmask[PSC_WD-1:0]) | (wb_dat_i[PSC_WD-1:0] & wmask[PSC_WD-1:0]);

    load_d = load_q;
    if (wr && wb_adr_i == REG_LOAD) load_d = load_wv;

    // Reload uses the old LOAD, so a write while running lands at the next wrap.
    count_d = count_q;
    if (tick)
      count_d = (count_q == '0) ? load_q : count_q - CNT_WD'(1);
    else if (wr && wb_adr_i == REG_LOAD && !ctrl_q[CTRL_EN])
      count_d = load_wv;

    to_d = to_q;
    if (wr && wb_adr_i == REG_STAT && wb_sel_i[0] && wb_dat_i[STAT_TO]) to_d = 1'b0;
    if (timeout) to_d = 1'b1;

    irq_d = to_q & ctrl_q[CTRL_IRQ_EN];

`ifdef WB_TIMER_PWM_EN
    duty_d = duty_q;
    if (wr && wb_adr_i == REG_DUTY)
      duty_d = (duty_q & ~wmask[CNT_WD-1:0]) | (wb_dat_i[CNT_WD-1:0] & wmask[CNT_WD-1:0]);
    pwm_d = ctrl_q[CTRL_EN] & ctrl_q[CTRL_PWM_EN] & (count_q < duty_q);
`else
    pwm_d = 1'b0;
`endif
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ctrl_q  <= '0;
      psc_q   <= '0;
      load_q  <= '0;
      count_q <= '0;
      to_q    <= 1'b0;
      irq_q   <= 1'b0;
      pwm_q   <= 1'b0;
`ifdef WB_TIMER_PWM_EN
      duty_q  <= '0;
`endif
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ctrl_q  <= ctrl_d;
      psc_q   <= psc_d;
      load_q  <= load_d;
      count_q <= count_d;
      to_q    <= to_d;
      irq_q   <= irq_d;
      pwm_q   <= pwm_d;
`ifdef WB_TIMER_PWM_EN
      duty_q  <= duty_d;
`endif
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;
  assign pwm_o    = pwm_q;

endmodule

// File: tb/tb_wb_timer_pwm.sv
// Directed self-checking bench for wb_timer_pwm (works with or without WB_TIMER_PWM_EN).
module tb_wb_timer_pwm;

`ifdef WB_TIMER_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [2:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack, irq, pwm;

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int last_edge;

  wb_timer_pwm #(.CNT_WD(32), .PSC_WD(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_sel_i  (sel),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .irq_o     (irq),
    .pwm_o     (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single Wishbone transfer; last_edge records the clock edge that raised ack.
  task automatic wb_xfer(input logic we_v, input logic [2:0] adr_v, input logic [31:0] dat_v,
                         input logic [3:0] sel_v, output logic [31:0] rd_v);
    int e;
    e = -1;
    rd_v = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = we_v; adr = adr_v; dat_w = dat_v; sel = sel_v;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        e = cyc_cnt;
        rd_v = dat_r;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (e < 0) check_eq("ack_timeout", 32'd0, 32'd1);
    last_edge = e;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'd0, 4'hF, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    int e0, rise, r, highs;
    bit seen_low;

    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_pwm", 32'(pwm), 32'd0);
    check_eq("rst_dat", dat_r, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_read(3'd0, rv); check_eq("rst_ctrl", rv, 32'd0);
    wb_read(3'd3, rv); check_eq("rst_count", rv, 32'd0);

    // Bus: byte-masked write, unmapped accesses, held strobe
    wb_write(3'd2, 32'hAABBCCDD, 4'b0010);
    wb_read(3'd2, rv); check_eq("load_sel", rv, 32'h0000CC00);
    wb_read(3'd3, rv); check_eq("count_follows_load", rv, 32'h0000CC00);
    wb_write(3'd6, 32'hFFFFFFFF, 4'hF);
    wb_read(3'd6, rv); check_eq("unmapped6", rv, 32'd0);
    wb_read(3'd7, rv); check_eq("unmapped7", rv, 32'd0);
    @(posedge clk); @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd7; sel = 4'hF;
    @(posedge clk); #1; check_eq("held_ack0", 32'(ack), 32'd1);
    @(posedge clk); #1; check_eq("held_ack1", 32'(ack), 32'd0);
    @(posedge clk); #1; check_eq("held_ack2", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0;

    // Periodic: PSC=3, LOAD=4 -> timeout every 20 clocks
    wb_write(3'd1, 32'd3, 4'hF);
    wb_write(3'd2, 32'd4, 4'hF);
    wb_write(3'd0, 32'h5, 4'hF);
    e0 = last_edge;
    rise = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (irq) begin rise = cyc_cnt; break; end
    end
    check_eq("irq_first_rise", 32'(rise - e0), 32'd21);
    wb_read(3'd4, rv); check_eq("stat_to_set", rv, 32'd1);
    wb_write(3'd4, 32'd1, 4'h1);
    wb_read(3'd3, rv); r = last_edge;
    check_eq("count_periodic", rv, 32'(4 - (((r - 1 - e0) / 4) % 5)));
    seen_low = 1'b0; rise = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!irq) seen_low = 1'b1;
      else if (seen_low) begin rise = cyc_cnt; break; end
    end
    check_eq("irq_second_rise", 32'(rise - e0), 32'd41);
    wb_write(3'd0, 32'h0, 4'hF);

    // One-shot: LOAD=2, PSC=0 -> single timeout 3 clocks after enable
    wb_write(3'd1, 32'd0, 4'hF);
    wb_write(3'd2, 32'd2, 4'hF);
    wb_write(3'd4, 32'd1, 4'hF);
    wb_write(3'd0, 32'h3, 4'hF);
    e0 = last_edge;
    for (int i = 0; i < 4; i++) begin
      wb_read(3'd4, rv); r = last_edge;
      check_eq("oneshot_to", rv, ((r - 1 - e0) >= 3) ? 32'd1 : 32'd0);
    end
    wb_read(3'd0, rv); check_eq("oneshot_ctrl", rv, 32'h2);
    wb_read(3'd3, rv); check_eq("oneshot_count", rv, 32'd2);

    // W1C racing a timeout on the same edge: set wins
    wb_write(3'd2, 32'd50, 4'hF);
    wb_write(3'd4, 32'd1, 4'hF);
    wb_read(3'd4, rv); check_eq("stat_cleared", rv, 32'd0);
    wb_write(3'd0, 32'h1, 4'hF);
    e0 = last_edge;
    while (cyc_cnt < e0 + 50) begin @(posedge clk); #1; end
    wb_write(3'd4, 32'd1, 4'hF);
    check_eq("race_edge", 32'(last_edge - e0), 32'd51);
    wb_write(3'd0, 32'h0, 4'hF);
    wb_read(3'd4, rv); check_eq("race_set_wins", rv, 32'd1);
    wb_write(3'd4, 32'd1, 4'hF);
    wb_read(3'd4, rv); check_eq("w1c_clears", rv, 32'd0);

    // LOAD=0, PSC=0: timeout every clock, no lockup
    wb_write(3'd2, 32'd0, 4'hF);
    wb_write(3'd0, 32'h5, 4'hF);
    repeat (5) @(posedge clk);
    #1; check_eq("lock_irq", 32'(irq), 32'd1);
    wb_read(3'd3, rv); check_eq("lock_count", rv, 32'd0);
    wb_write(3'd4, 32'd1, 4'hF);
    wb_read(3'd4, rv); check_eq("lock_to", rv, 32'd1);
    wb_write(3'd0, 32'h0, 4'hF);

    // PWM: LOAD=9, DUTY=3 -> high 3 of every 10 clocks
    wb_write(3'd2, 32'd9, 4'hF);
    wb_write(3'd5, 32'd3, 4'hF);
    wb_write(3'd0, 32'h9, 4'hF);
    wb_read(3'd5, rv); check_eq("duty_rd", rv, PWM_ON ? 32'd3 : 32'd0);
    wb_read(3'd0, rv); check_eq("pwm_ctrl", rv, PWM_ON ? 32'h9 : 32'h1);
    repeat (12) @(posedge clk);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pwm) highs++;
    end
    check_eq("pwm_highs", 32'(highs), PWM_ON ? 32'd6 : 32'd0);

    // Reset mid-count at COUNT=5
    wb_write(3'd0, 32'h0, 4'hF);
    wb_write(3'd2, 32'd20, 4'hF);
    wb_write(3'd5, 32'd10, 4'hF);
    wb_read(3'd2, rv); check_eq("load20", rv, 32'd20);
    wb_write(3'd0, 32'hD, 4'hF);
    e0 = last_edge;
    while (cyc_cnt < e0 + 15) begin @(posedge clk); #1; end
    check_eq("pre_rst_irq", 32'(irq), 32'd1);
    check_eq("pre_rst_pwm", 32'(pwm), PWM_ON ? 32'd1 : 32'd0);
    check_eq("pre_rst_dat", dat_r, 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_ack", 32'(ack), 32'd0);
    check_eq("async_irq", 32'(irq), 32'd0);
    check_eq("async_pwm", 32'(pwm), 32'd0);
    check_eq("async_dat", dat_r, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_read(3'd3, rv); check_eq("post_rst_count", rv, 32'd0);
    wb_read(3'd0, rv); check_eq("post_rst_ctrl", rv, 32'd0);
    wb_read(3'd4, rv); check_eq("post_rst_stat", rv, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
